vga_rx_monitor: RTL and testbench
=================================

# vga_rx_monitor

Receive-side monitor for the 640x480 VGA stream that the display path drives out of the board. It samples hsync/vsync and the 8-bit RGB bus on the pixel clock and recovers the transmitter's column/row counters. It checks sync pulse widths and line/frame lengths, qualifies lock, and emits per-pixel coordinates plus a per-frame pixel checksum. It sits beside the VGA output pins for loopback self-test and as the bench's golden observer.

## Interface
- HPIXELS, 800, clocks per line
- VLINES, 521, lines per frame
- HPULSE, 96, hsync low width (clocks)
- VPULSE, 2, vsync low width (lines)
- HBP, 144, first active column
- HFP, 784, first column after active
- VBP, 31, first active line
- VFP, 511, first line after active
- LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
- dclk  in  1  pixel clock, 25 MHz
- clr  in  1  reset; one clock; reset is asynchronous and active-low
- hsync  in  1  active-low, synchronous to dclk
- vsync  in  1  active-low, synchronous to dclk
- red  in  3  pixel red
- green  in  3  pixel green
- blue  in  2  pixel blue
- locked  out  1  stream qualified
- pix_valid  out  1  x/y/pix_rgb describe an active pixel
- x  out  10  active column 0..639
- y  out  9  active row 0..479
- pix_rgb  out  8  {red,green,blue}
- frame_done  out  1  one-cycle pulse; frame_sum updated
- frame_sum  out  16  wrapping sum of pix_rgb over last frame's valid pixels
- sync_err  out  1  one-cycle pulse on any check failure
- err_count  out  8  saturating count of sync_err pulses

## Operation
- Stage 1 registers the inputs into hs_q, vs_q, and rgb_q each cycle.
- hfall = ~hsync & hs_q. hrise = hsync & ~hs_q. vfall and vrise are defined the same way on vsync.
- Column counter hcnt (10b): on hfall load 0, else increment, saturating at 1023. The invariant is that hcnt equals the transmitter column of the sample in stage 1.
- Row counter vcnt (10b): updates only on hfall. If vfall coincides, load 0; else increment, saturating at 1023.
- Checks apply only once the corresponding counter has been initialised by a prior fall edge. Each check raises sync_err for one cycle on failure:
  - on hrise: hcnt must equal HPULSE-1
  - on hfall: hcnt must equal HPIXELS-1
  - on vrise: vcnt must equal VPULSE-1
  - on vfall: vcnt must equal VLINES-1
- sync_err increments err_count, which saturates at 255.
- Lock FSM, 2-bit state, with clean-frame counter cf:
  - SEARCH: on vfall go to SYNC with cf=0.
  - SYNC: any sync_err clears cf. On vfall with no error in the frame, cf++; when cf reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any sync_err returns to SEARCH.
  - locked = (state==LOCKED).
- Stage 2 output register:
  - pix_valid <= locked & HBP<=hcnt<HFP & VBP<=vcnt<VFP
  - x <= hcnt-HBP, truncated to 10b
  - y <= vcnt-VBP, truncated to 9b
  - pix_rgb <= rgb_q
  - x, y and pix_rgb update every cycle regardless of pix_valid.
- Checksum: an accumulator adds pix_rgb (zero-extended) whenever pix_valid, wrapping modulo 2^16.
  - On vfall while locked: frame_sum <= accumulator, including any addition made that cycle; the accumulator clears; frame_done pulses one cycle later.
  - On vfall while not locked: the accumulator clears and frame_done does not pulse.
- Simultaneous events: when vfall and hfall coincide, checks run in the order hfall check, then vfall check. If either fails, the frame is not counted clean.

## Timing
- Reset (clr=0) forces all outputs, counters and stage registers to 0, state to SEARCH, and hs_q/vs_q to 1. Assertion mid-frame aborts immediately. Relock requires a full SEARCH→SYNC→LOCKED sequence.
- Latency: the input sample at transmitter column c appears on x/pix_rgb two dclk edges later.
- locked rises on the vfall edge that completes the LOCK_FRAMES-th clean frame, and falls on the edge after the offending sample.
- frame_done is asserted exactly once per vfall while locked: 1 pulse per 416800 cycles for a nominal stream.

## Test plan
- Nominal stream, all pixels r=0,g=7,b=3 (pix_rgb 0x1F), reset released before the first frame -> locked after the 3rd vfall; every frame_done shows frame_sum=0x5000; sync_err never asserts.
- Same stream, pixel at transmitter hc=144, vc=31 set to 0xFF -> pix_valid with x=0, y=0, pix_rgb=0xFF two cycles after the sample; frame_sum=0x50E0.
- One line shortened to 799 clocks while locked -> single sync_err, err_count=1, locked drops, relocks after 3 further vfalls.
- hsync pulse widened to 97 clocks on one line -> sync_err on that hrise, state SEARCH, no frame_done for that frame.
- clr asserted at mid-frame hc=400, vc=200 while locked -> all outputs 0 immediately; after release, locked reasserts only after 3 vfalls.
- 300 consecutive malformed lines -> err_count saturates at 255; locked stays 0.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// Receive-side monitor for a VGA stream: recovers column/row counters from the syncs,
// checks sync timing, qualifies lock and emits pixel coordinates plus a per-frame checksum.
module vga_rx_monitor #(
  parameter int HPIXELS     = 800,
  parameter int VLINES      = 521,
  parameter int HPULSE      = 96,
  parameter int VPULSE      = 2,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  red,
  input  logic [2:0]  green,
  input  logic [1:0]  blue,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic [7:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] H_PW   = 10'(HPULSE - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] V_PW   = 10'(VPULSE - 1);
  localparam logic [9:0] H_BP   = 10'(HBP);
  localparam logic [9:0] H_FP   = 10'(HFP);
  localparam logic [9:0] V_BP   = 10'(VBP);
  localparam logic [9:0] V_FP   = 10'(VFP);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  state_t      state, state_n;
  logic [3:0]  cf, cf_n, cf_inc;
  logic        hs_q, vs_q;
  logic [7:0]  rgb_q;
  logic [9:0]  hcnt, vcnt;
  logic        h_init, v_init, frame_bad;
  logic        hfall, hrise, vfall, vrise, err;
  logic [15:0] acc, acc_next;

  // Edges compare the live input against the stage-1 copy, so hcnt/vcnt track the sample in rgb_q.
  assign hfall = ~hsync & hs_q;
  assign hrise = hsync & ~hs_q;
  assign vfall = ~vsync & vs_q;
  assign vrise = vsync & ~vs_q;

  assign err = (hrise & h_init & (hcnt != H_PW))
             | (hfall & h_init & (hcnt != H_LAST))
             | (vrise & v_init & (vcnt != V_PW))
             | (vfall & v_init & (vcnt != V_LAST));

  assign locked   = (state == LOCKED);
  assign cf_inc   = cf + 4'd1;
  assign acc_next = pix_valid ? acc + {8'd0, pix_rgb} : acc;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cf_n    = cf;
    case (state)
      SEARCH: if (vfall) begin
        state_n = SYNC;
        cf_n    = '0;
      end
      SYNC: begin
        if (err) begin
          cf_n = '0;
        end else if (vfall && !frame_bad) begin
          cf_n = cf_inc;
          if (cf_inc == LOCK_N) state_n = LOCKED;
        end
      end
      LOCKED: if (err) state_n = SEARCH;
      default: state_n = SEARCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      // Syncs idle high, so the stage-1 copies reset high to avoid a false fall edge.
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      rgb_q      <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      h_init     <= 1'b0;
      v_init     <= 1'b0;
      frame_bad  <= 1'b0;
      state      <= SEARCH;
      cf         <= '0;
      sync_err   <= 1'b0;
      err_count  <= '0;
      pix_valid  <= 1'b0;
      x          <= '0;
      y          <= '0;
      pix_rgb    <= '0;
      acc        <= '0;
      frame_sum  <= '0;
      frame_done <= 1'b0;
    end else begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      rgb_q <= {red, green, blue};

      if (hfall)                 hcnt <= '0;
      else if (hcnt != 10'h3FF)  hcnt <= hcnt + 10'd1;
      if (hfall) begin
        h_init <= 1'b1;
        if (vfall) begin
          vcnt   <= '0;
          v_init <= 1'b1;
        end else if (vcnt != 10'h3FF) begin
          vcnt <= vcnt + 10'd1;
        end
      end

      if (vfall)    frame_bad <= 1'b0;
      else if (err) frame_bad <= 1'b1;

      state    <= state_n;
      cf       <= cf_n;
      sync_err <= err;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;

      pix_valid <= locked && (hcnt >= H_BP) && (hcnt < H_FP) && (vcnt >= V_BP) && (vcnt < V_FP);
      x         <= hcnt - H_BP;
      y         <= 9'(vcnt - V_BP);
      pix_rgb   <= rgb_q;

      // The sum published at vfall includes this cycle's addition; unlocked frames are discarded.
      if (vfall) begin
        acc <= '0;
        if (locked) frame_sum <= acc_next;
      end else begin
        acc <= acc_next;
      end
      frame_done <= vfall & locked;
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a shrunken raster (40x12 clocks/lines)
// so lock, checksum, error and reset scenarios each take only a few frames.
module tb_vga_rx_monitor;

  localparam int HP = 40, VL = 12, HPU = 4, VPU = 2, HB = 8, HF = 36, VB = 3, VF = 10;

  logic        dclk = 1'b0, clr = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [2:0]  red = '0, green = '0;
  logic [1:0]  blue = '0;
  logic        locked, pix_valid, frame_done, sync_err;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [7:0]  pix_rgb, err_count;
  logic [15:0] frame_sum;

  int checks = 0, errors = 0;
  int serr_seen = 0, fd_seen = 0, fd_mark = 0;
  int sp_h = -1, sp_v = -1;

  vga_rx_monitor #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPU), .VPULSE(VPU),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(2)
  ) dut (
    .dclk(dclk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .locked(locked), .pix_valid(pix_valid), .x(x), .y(y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_sum(frame_sum),
    .sync_err(sync_err), .err_count(err_count)
  );

  always #5 dclk = ~dclk;

  always @(negedge dclk) begin
    if (sync_err === 1'b1)   serr_seen <= serr_seen + 1;
    if (frame_done === 1'b1) fd_seen   <= fd_seen + 1;
  end

  initial begin
    #600_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives columns c0..c1-1 of line vc; each call returns #1 after the edge that sampled the last column.
  task automatic line_seg(input int vc, input int c0, input int c1, input int hpw);
    for (int c = c0; c < c1; c++) begin
      hsync = (c >= hpw);
      vsync = (vc >= VPU);
      {red, green, blue} = (vc == sp_v && c == sp_h) ? 8'hFF : 8'h1F;
      @(posedge dclk);
      #1;
    end
  endtask

  task automatic lines(input int v0, input int v1);
    for (int vc = v0; vc < v1; vc++) line_seg(vc, 0, HP, HPU);
  endtask

  task automatic rest_of_frame();
    line_seg(0, 1, HP, HPU);
    lines(1, VL);
  endtask

  task automatic frame();
    line_seg(0, 0, 1, HPU);
    rest_of_frame();
  endtask

  initial begin
    repeat (3) @(posedge dclk);
    #1;
    check("rst_locked",     32'(locked),     0);
    check("rst_pix_valid",  32'(pix_valid),  0);
    check("rst_x",          32'(x),          0);
    check("rst_y",          32'(y),          0);
    check("rst_pix_rgb",    32'(pix_rgb),    0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_sum",  32'(frame_sum),  0);
    check("rst_sync_err",   32'(sync_err),   0);
    check("rst_err_count",  32'(err_count),  0);
    clr = 1'b1;

    // Nominal lock: SEARCH->SYNC, one clean frame, LOCKED on the third vfall.
    frame();
    frame();
    check("unlocked_after_2_vfalls", 32'(locked), 0);
    line_seg(0, 0, 1, HPU);
    check("locked_on_3rd_vfall", 32'(locked), 1);
    check("no_fd_on_lock_edge",  32'(frame_done), 0);
    rest_of_frame();

    // 28x7 active pixels of 0x1F -> 196*31 = 6076 = 0x17BC.
    line_seg(0, 0, 1, HPU);
    check("fd_frame3",  32'(frame_done), 1);
    check("sum_frame3", 32'(frame_sum), 32'h17BC);
    sp_h = HB;
    sp_v = VB;
    line_seg(0, 1, HP, HPU);
    lines(1, VB);
    line_seg(VB, 0, HB + 1, HPU);
    check("pv_before_hbp", 32'(pix_valid), 0);
    check("x_before_hbp",  32'(x), 32'h3FF);
    line_seg(VB, HB + 1, HB + 2, HPU);
    check("pv_first_pix",  32'(pix_valid), 1);
    check("x_first_pix",   32'(x), 0);
    check("y_first_pix",   32'(y), 0);
    check("rgb_first_pix", 32'(pix_rgb), 32'hFF);
    line_seg(VB, HB + 2, HP, HPU);
    sp_h = -1;
    sp_v = -1;
    lines(VB + 1, VL);

    // One 0xFF pixel replaces a 0x1F: 6076 + 224 = 6300 = 0x189C.
    line_seg(0, 0, 1, HPU);
    check("fd_frame4",  32'(frame_done), 1);
    check("sum_frame4", 32'(frame_sum), 32'h189C);
    check("fd_one_cycle_prev", 32'(fd_seen), 1);
    line_seg(0, 1, HP, HPU);
    lines(1, VF - 1);
    line_seg(VF - 1, 0, HF + 1, HPU);
    check("pv_last_col", 32'(pix_valid), 1);
    check("x_last_col",  32'(x), 27);
    check("y_last_row",  32'(y), 6);
    line_seg(VF - 1, HF + 1, HF + 2, HPU);
    check("pv_at_hfp", 32'(pix_valid), 0);
    line_seg(VF - 1, HF + 2, HP, HPU);
    lines(VF, VL);
    check("no_serr_nominal", 32'(serr_seen), 0);
    check("errcnt_nominal",  32'(err_count), 0);

    // Short line (39 clocks) while locked.
    line_seg(0, 0, 1, HPU);
    check("sum_frame5", 32'(frame_sum), 32'h17BC);
    line_seg(0, 1, HP, HPU);
    lines(1, 2);
    line_seg(2, 0, HP - 1, HPU);
    line_seg(3, 0, 1, HPU);
    check("short_serr",    32'(sync_err), 1);
    check("short_errcnt",  32'(err_count), 1);
    check("short_unlock",  32'(locked), 0);
    line_seg(3, 1, 2, HPU);
    check("short_serr_1cyc", 32'(sync_err), 0);
    line_seg(3, 2, HP, HPU);
    lines(4, VL);
    line_seg(0, 0, 1, HPU);
    check("short_no_fd",   32'(frame_done), 0);
    rest_of_frame();
    frame();
    check("relock_not_yet", 32'(locked), 0);
    line_seg(0, 0, 1, HPU);
    check("relock_3rd_vfall", 32'(locked), 1);
    rest_of_frame();

    // Partial frame before relock is discarded; first full locked frame sums cleanly.
    line_seg(0, 0, 1, HPU);
    check("fd_after_relock",  32'(frame_done), 1);
    check("sum_after_relock", 32'(frame_sum), 32'h17BC);
    line_seg(0, 1, HP, HPU);
    lines(1, 5);
    line_seg(5, 0, HPU + 1, HPU + 1);
    line_seg(5, HPU + 1, HPU + 2, HPU + 1);
    check("wide_serr",   32'(sync_err), 1);
    check("wide_unlock", 32'(locked), 0);
    check("wide_errcnt", 32'(err_count), 2);
    line_seg(5, HPU + 2, HP, HPU + 1);
    lines(6, VL);
    fd_mark = fd_seen;
    line_seg(0, 0, 1, HPU);
    check("wide_no_fd", 32'(frame_done), 0);
    rest_of_frame();
    check("wide_no_fd_count", 32'(fd_seen), 32'(fd_mark));
    frame();
    line_seg(0, 0, 1, HPU);
    check("relock_after_wide", 32'(locked), 1);

    // Mid-frame reset while locked and showing an active pixel.
    line_seg(0, 1, HP, HPU);
    lines(1, 5);
    line_seg(5, 0, 20, HPU);
    check("pre_clr_pv", 32'(pix_valid), 1);
    clr = 1'b0;
    #1;
    check("clr_locked",    32'(locked), 0);
    check("clr_pix_valid", 32'(pix_valid), 0);
    check("clr_x",         32'(x), 0);
    check("clr_y",         32'(y), 0);
    check("clr_pix_rgb",   32'(pix_rgb), 0);
    check("clr_frame_sum", 32'(frame_sum), 0);
    check("clr_err_count", 32'(err_count), 0);
    line_seg(5, 20, 22, HPU);
    check("clr_held_x", 32'(x), 0);
    clr = 1'b1;
    line_seg(5, 22, HP, HPU);
    lines(6, VL);
    frame();
    frame();
    check("clr_relock_not_yet", 32'(locked), 0);
    line_seg(0, 0, 1, HPU);
    check("clr_relock_3rd", 32'(locked), 1);
    check("clr_relock_errcnt", 32'(err_count), 0);

    // 300 lines of 30 clocks: one error pulse per line start, saturating at 255.
    line_seg(0, 1, 30, HPU);
    repeat (100) line_seg(5, 0, 30, HPU);
    check("bad_errcnt_100", 32'(err_count), 100);
    check("bad_unlocked",   32'(locked), 0);
    repeat (200) line_seg(5, 0, 30, HPU);
    check("bad_errcnt_sat",   32'(err_count), 255);
    check("bad_still_unlock", 32'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
